// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the R2MDC FFT stage controllers. It holds:
//   - the controller state encoding,
//   - a constant-evaluable ceiling log2,
//   - helpers for the per-stage derived constants:
//       HALF   = N/2            sample pairs per frame
//       D      = N >> (STAGE+2) delay-line depth of the stage
//       TW_MOD = N >> (STAGE+1) twiddle index period of the stage
// -----------------------------------------------------------------------------
package fft_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_e;

   // Smallest r with 2**r >= value (0 for value <= 1).
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < value) begin
         v = v << 1;
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int half_of(input int n);
      return n / 2;
   endfunction

   function automatic int dly_of(input int n, input int stage);
      return n >> (stage + 2);
   endfunction

   function automatic int twmod_of(input int n, input int stage);
      return n >> (stage + 1);
   endfunction

endpackage

// File: rtl/fft_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// fft_stage_ctrl_if
// Bundle between one stage controller and the datapath it sequences.
// Handshake: in_valid marks a sample pair present in the current cycle and is
// never back-pressured; in_sof is only meaningful when in_valid is high.
// Control outputs are registered and describe the cycle in which they are
// high (dly_en/bf_en are single-cycle strobes, out_valid/out_sof trail bf_en
// by the butterfly latency).
//   master : the stage controller (drives the control outputs)
//   slave  : the sample source / datapath side
// Signals:
//   in_valid, in_sof        pair present / pair is pair 0 of a frame
//   dly_en, sw_sel          delay-line shift strobe, commutator select
//   bf_en, tw_addr          butterfly operands valid, twiddle ROM address
//   out_valid, out_sof      butterfly outputs valid, first butterfly of frame
//   busy, err_sof           controller not idle, protocol-violation pulse
//   dbg_state               controller state for observation
// -----------------------------------------------------------------------------
interface fft_stage_ctrl_if
   import fft_pkg::*;
#(
   parameter int N = 16
);
   localparam int ADDR_W = clog2(N / 2);

   logic              in_valid;
   logic              in_sof;
   logic              dly_en;
   logic              sw_sel;
   logic              bf_en;
   logic [ADDR_W-1:0] tw_addr;
   logic              out_valid;
   logic              out_sof;
   logic              busy;
   logic              err_sof;
   state_e            dbg_state;

   modport master (
      input  in_valid, in_sof,
      output dly_en, sw_sel, bf_en, tw_addr, out_valid, out_sof,
             busy, err_sof, dbg_state
   );

   modport slave (
      output in_valid, in_sof,
      input  dly_en, sw_sel, bf_en, tw_addr, out_valid, out_sof,
             busy, err_sof, dbg_state
   );

endinterface

// File: rtl/fft_valid_pipe.sv
// -----------------------------------------------------------------------------
// fft_valid_pipe
// LAT-deep register chain carrying {valid, sof} from the butterfly input to its
// output, matching the butterfly's output register depth.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   valid_i, sof_i      butterfly operands valid / first butterfly of frame
//   valid_o, sof_o      the same, LAT cycles later
// -----------------------------------------------------------------------------
module fft_valid_pipe #(
   parameter int LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic valid_i,
   input  logic sof_i,
   output logic valid_o,
   output logic sof_o
);

   logic [LAT-1:0] valid_q;
   logic [LAT-1:0] sof_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         sof_q   <= '0;
      end else begin
         valid_q[0] <= valid_i;
         // sof is only meaningful alongside valid.
         sof_q[0]   <= sof_i & valid_i;
         for (int i = 1; i < LAT; i++) begin
            valid_q[i] <= valid_q[i-1];
            sof_q[i]   <= sof_q[i-1];
         end
      end
   end

   assign valid_o = valid_q[LAT-1];
   assign sof_o   = sof_q[LAT-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// -----------------------------------------------------------------------------
// fft_stage_ctrl
// Sequencing controller for one radix-2 butterfly stage of an R2MDC FFT.
// It counts delay-line ticks within a frame, strobes the delay-line shift,
// selects the commutator, flags butterfly operand cycles with their twiddle
// address, and flushes the delay line at the end of each frame.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          fft_stage_ctrl_if.master (inputs in_valid/in_sof, all
//                control outputs and the state for observation)
// Frame timeline (tick index t, 0 .. HALF+D-1):
//   t <  D      FILL   load the delay line only
//   D <= t < HALF RUN  butterfly j = t-D per accepted pair
//   t >= HALF   DRAIN  flush ticks, butterflies j = HALF-D .. HALF-1
// A new frame may start during DRAIN; its pairs are counted in a separate
// pending counter and the last flush tick hands over to FILL or RUN.
// -----------------------------------------------------------------------------
module fft_stage_ctrl
   import fft_pkg::*;
#(
   parameter int N      = 16,
   parameter int STAGE  = 0,
   parameter int BF_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   fft_stage_ctrl_if.master bus
);

   localparam int HALF   = half_of(N);
   localparam int D      = dly_of(N, STAGE);
   localparam int TW_MOD = twmod_of(N, STAGE);
   localparam int ADDR_W = clog2(HALF);
   localparam int CNT_W  = clog2(N);
   // D is a power of two, so (t / D) mod 2 is a single bit of t.
   localparam int SW_BIT = clog2(D);

   localparam logic [CNT_W-1:0] D_CNT      = CNT_W'(D);
   localparam logic [CNT_W-1:0] LAST_FILL  = CNT_W'(D - 1);
   localparam logic [CNT_W-1:0] LAST_PAIR  = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(HALF + D - 1);
   localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);
   // Pair 0 of a frame is the last fill tick only when D == 1.
   localparam state_e AFTER_SOF = (D == 1) ? RUN : FILL;

   // State and counters
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  tcnt_q, tcnt_d;   // next tick index of the current frame
   logic              pend_q, pend_d;   // next frame started during DRAIN
   logic [CNT_W-1:0]  pcnt_q, pcnt_d;   // pairs of that next frame so far

   // Per-cycle decisions from the next-state logic
   logic              tick;
   logic              bf_tick;
   logic              err_now;
   logic [CNT_W-1:0]  tick_idx;
   logic [CNT_W-1:0]  j;

   // Registered outputs
   logic              dly_en_q, dly_en_d;
   logic              sw_sel_q, sw_sel_d;
   logic              bf_en_q, bf_en_d;
   logic [ADDR_W-1:0] tw_addr_q, tw_addr_d;
   logic              bf_sof_q, bf_sof_d;
   logic              err_sof_q, err_sof_d;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         tcnt_q    <= '0;
         pend_q    <= 1'b0;
         pcnt_q    <= '0;
         dly_en_q  <= 1'b0;
         sw_sel_q  <= 1'b0;
         bf_en_q   <= 1'b0;
         tw_addr_q <= '0;
         bf_sof_q  <= 1'b0;
         err_sof_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tcnt_q    <= tcnt_d;
         pend_q    <= pend_d;
         pcnt_q    <= pcnt_d;
         dly_en_q  <= dly_en_d;
         sw_sel_q  <= sw_sel_d;
         bf_en_q   <= bf_en_d;
         tw_addr_q <= tw_addr_d;
         bf_sof_q  <= bf_sof_d;
         err_sof_q <= err_sof_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d  = state_q;
      tcnt_d   = tcnt_q;
      pend_d   = pend_q;
      pcnt_d   = pcnt_q;
      tick     = 1'b0;
      bf_tick  = 1'b0;
      err_now  = 1'b0;
      tick_idx = tcnt_q;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               if (bus.in_sof) begin
                  tick     = 1'b1;
                  tick_idx = '0;
                  tcnt_d   = ONE_CNT;
                  state_d  = AFTER_SOF;
               end else begin
                  err_now = 1'b1;
               end
            end
         end

         FILL, RUN: begin
            if (bus.in_valid) begin
               tick = 1'b1;
               if (bus.in_sof) begin
                  // Abandon the current frame; this pair restarts the count.
                  err_now  = 1'b1;
                  tick_idx = '0;
                  tcnt_d   = ONE_CNT;
                  state_d  = AFTER_SOF;
               end else begin
                  tcnt_d = tcnt_q + ONE_CNT;
                  if (state_q == FILL) begin
                     if (tcnt_q == LAST_FILL) state_d = RUN;
                  end else begin
                     bf_tick = 1'b1;
                     if (tcnt_q == LAST_PAIR) state_d = DRAIN;
                  end
               end
            end
         end

         DRAIN: begin
            // Every DRAIN cycle shifts the delay line and issues a butterfly.
            tick    = 1'b1;
            bf_tick = 1'b1;
            tcnt_d  = tcnt_q + ONE_CNT;
            if (bus.in_valid) begin
               if (bus.in_sof) begin
                  // A second sof while a next frame is already filling is the
                  // same violation as sof during FILL: restart its count.
                  err_now = pend_q;
                  pend_d  = 1'b1;
                  pcnt_d  = ONE_CNT;
               end else if (pend_q) begin
                  pcnt_d = pcnt_q + ONE_CNT;
               end else begin
                  err_now = 1'b1;
               end
            end
            if (tcnt_q == LAST_FLUSH) begin
               if (pend_d) begin
                  // Hand the overlapped fill count to the next frame.
                  tcnt_d  = pcnt_d;
                  state_d = (pcnt_d >= D_CNT) ? RUN : FILL;
               end else begin
                  tcnt_d  = '0;
                  state_d = IDLE;
               end
               pend_d = 1'b0;
               pcnt_d = '0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      dly_en_d  = tick;
      bf_en_d   = bf_tick;
      err_sof_d = err_now;
      sw_sel_d  = sw_sel_q;
      tw_addr_d = tw_addr_q;
      bf_sof_d  = 1'b0;
      j         = tick_idx - D_CNT;

      if (tick) begin
         sw_sel_d = tick_idx[SW_BIT];
      end
      if (bf_tick) begin
         tw_addr_d = ADDR_W'((32'(j) % TW_MOD) << STAGE);
         bf_sof_d  = (j == '0);
      end
   end

   fft_valid_pipe #(
      .LAT (BF_LAT)
   ) u_valid_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (bf_en_q),
      .sof_i   (bf_sof_q),
      .valid_o (bus.out_valid),
      .sof_o   (bus.out_sof)
   );

   assign bus.dly_en    = dly_en_q;
   assign bus.sw_sel    = sw_sel_q;
   assign bus.bf_en     = bf_en_q;
   assign bus.tw_addr   = tw_addr_q;
   assign bus.err_sof   = err_sof_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.dbg_state = state_q;

endmodule

// File: doc/fft_stage_ctrl.md
Name: fft_stage_ctrl

Overview:
Sequencing controller for one radix-2 butterfly stage of the R2MDC pipelined FFT. It counts incoming sample pairs and drives the stage's delay-line shift enable and commutator select. It issues butterfly-operand valid and twiddle ROM addresses, and flushes the delay line at end of frame. One instance sits beside each butterfly stage; the datapath (delay lines, commutator, butterfly, twiddle ROM) lives outside this block.

Parameters:
N, 16, FFT size in points; power of 2, >= 8
STAGE, 0, stage index, 0 .. log2(N)-2
BF_LAT, 1, butterfly output register depth in cycles (>= 1); sets bf_en -> out_valid delay
ADDR_W, log2(N/2), twiddle address width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  input sample pair present this cycle (no backpressure)
in_sof  in  1  qualifies in_valid: pair is pair 0 of a frame
dly_en  out  1  delay line shift enable (one tick)
sw_sel  out  1  commutator: 0 = straight, 1 = cross
bf_en  out  1  butterfly operands valid this cycle
tw_addr  out  ADDR_W  twiddle ROM address for current butterfly
out_valid  out  1  butterfly outputs valid
out_sof  out  1  with out_valid, marks butterfly 0 of a frame
busy  out  1  state != IDLE
err_sof  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Derived constants: HALF = N/2 pairs per frame; D = N >> (STAGE+2), the delay depth (>= 1); TW_MOD = N >> (STAGE+1).
- Reset (async, rst_n=0): state IDLE; all counters 0; every output 0 (tw_addr = 0).
- Tick: any cycle where the delay line shifts. It is either an accepted pair (in_valid in FILL/RUN, or in_valid&in_sof in IDLE/DRAIN) or a flush tick (every DRAIN cycle). tcnt counts ticks within the frame, 0 .. HALF+D-1.
- States:
  - IDLE: in_valid&in_sof accepts pair 0 -> FILL. in_valid without in_sof is ignored and pulses err_sof.
  - FILL: the first D ticks only load the delay line; no butterfly. After tick D-1 -> RUN.
  - RUN: each accepted pair k (k >= D) issues butterfly j = k-D. After pair HALF-1 -> DRAIN.
  - DRAIN: each cycle is a tick and issues butterfly j = HALF-D .. HALF-1. After D ticks -> IDLE.
  - DRAIN with in_valid&in_sof: the pair is accepted as pair 0 of the next frame and also serves as the flush tick. The next frame's fill count overlaps the old frame's drain, so the last drain tick goes -> RUN, not IDLE. Back-to-back frames have zero bubbles.
  - DRAIN with in_valid and no in_sof: the pair is dropped and err_sof pulses.
- Outputs are registered and appear in the cycle after the tick edge:
  - dly_en = 1.
  - sw_sel = (tcnt / D) mod 2.
  - bf_en = 1 for butterfly ticks.
  - tw_addr = (j mod TW_MOD) << STAGE while bf_en = 1; it holds its last value otherwise.
- out_valid and out_sof are bf_en and (j == 0) delayed by BF_LAT cycles.
- in_sof in FILL or RUN: err_sof pulses, the current frame is abandoned (no further bf_en for it), and the pair is taken as pair 0 of a new frame -> FILL. Butterflies already in the BF_LAT pipe still emerge.
- in_valid gaps in FILL/RUN stall all counters; outputs deassert except tw_addr and sw_sel, which hold.
- Reset mid-frame: immediate return to the reset values, including the out_valid pipe.

Decomposition:
- Package fft_pkg:
  - clog2 function;
  - derived HALF, D and TW_MOD functions of (N, STAGE);
  - state enum IDLE/FILL/RUN/DRAIN (2 bits).
- Sub-module fft_valid_pipe: BF_LAT-deep register chain for {bf_en, sof} with async active-low reset. It is reused by other stages.

Test Plan:
- N=16, STAGE=0, 8 consecutive pairs with sof on pair 0:
  - bf_en high 8 cycles, starting the cycle after pair 4;
  - tw_addr 0..7;
  - sw_sel toggles every 4 ticks;
  - busy falls after 4 flush ticks;
  - out_valid lags bf_en by 1, with out_sof on the first.
- N=16, STAGE=1 (D=2): tw_addr sequence 0,2,4,6,0,2,4,6; sw_sel period 4 ticks.
- Two frames back-to-back (sof on cycle 8) -> 16 contiguous bf_en cycles with no bubble, out_sof exactly twice, state never returns to IDLE between frames.
- Gaps: in_valid low on cycles 2 and 6 of a frame -> counters stall; total bf_en count is still 8; tw_addr sequence is unchanged.
- sof during RUN at pair 5 -> err_sof pulses once; the old frame issues only 1 butterfly (j=0); the new frame completes normally with 8 butterflies.
- rst_n low mid-DRAIN (asynchronous, between edges) -> every output reads 0 immediately; in_valid without sof afterwards -> ignored, err_sof=1.
